// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out serializer, LSB first, with valid/ready
// load handshake and support for back-to-back frames with no idle gap.
// Optional build macro: PISO_TX_PARITY_EN appends an even-parity bit to
// every frame (frame length WIDTH+1 instead of WIDTH).
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             last_data;

`ifdef PISO_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Final data bit of the frame is on so this cycle.
  assign last_data = (state_q == SHIFT) && (cnt_q == CNT_LAST);

  // A load is taken whenever upstream offers and we can take it; an accept
  // on the last-bit edge restarts SHIFT so frames run back to back.
  assign accept = load_valid && load_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: an accept always wins over frame completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (accept) begin
          state_d = SHIFT;
        end else if (last_data) begin
`ifdef PISO_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        state_d = accept ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output decode, from registered state only (load_ready included).
  always_comb begin
    so       = 1'b0;
    so_last  = 1'b0;
    so_valid = (state_q != IDLE);
    case (state_q)
      SHIFT: begin
        so = shreg_q[0];
`ifndef PISO_TX_PARITY_EN
        so_last = last_data;
`endif
      end
`ifdef PISO_TX_PARITY_EN
      PARITY: begin
        so      = parity_q;
        so_last = 1'b1;
      end
`endif
      default: ;
    endcase
    busy       = so_valid;
    load_ready = (state_q == IDLE) || so_last;
  end

  // Datapath next values: load on accept, otherwise shift toward bit 0.
  // The counter returns to 0 at frame end so it never passes WIDTH-1.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      shreg_d = din;
      cnt_d   = '0;
`ifdef PISO_TX_PARITY_EN
      parity_d = ^din;
`endif
    end else if (state_q == SHIFT) begin
      shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      cnt_d   = last_data ? '0 : cnt_q + 1'b1;
    end
  end

  // Datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PISO_TX_PARITY_EN
  // Parity bit latched at accept and replayed in the PARITY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_piso_tx.sv
// Testbench for piso_tx (WIDTH=4). Directed scenarios with hand-computed
// expected serial sequences; parity expectations used when
// PISO_TX_PARITY_EN is defined.
module tb_piso_tx;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             so;
  logic             so_valid;
  logic             so_last;
  logic             busy;

  int tests_run;
  int tests_failed;

  piso_tx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .so         (so),
    .so_valid   (so_valid),
    .so_last    (so_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    din        = '0;
    load_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      tests_run++;
      if (so !== 1'b0 || so_valid !== 1'b0 || load_ready !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle c%0d: so=%b so_valid=%b load_ready=%b busy=%b, required 0 0 1 0",
                 c, so, so_valid, load_ready, busy);
      end
    end
    $display("[TB] reset idle checked");
  endtask

`ifndef PISO_TX_PARITY_EN
  task automatic test_single();
    logic [3:0] exp_bits;
    exp_bits   = 4'b1011;
    din        = 4'b1011;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (so !== exp_bits[i] || so_valid !== 1'b1 || so_last !== (i == 3) ||
          load_ready !== (i == 3)) begin
        tests_failed++;
        $display("FAIL single bit%0d: so=%b v=%b last=%b rdy=%b, required so=%b v=1 last=%b rdy=%b",
                 i, so, so_valid, so_last, load_ready, exp_bits[i], (i == 3), (i == 3));
      end
      step();
    end
    tests_run++;
    if (so_valid !== 1'b0 || load_ready !== 1'b1 || so !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_end: so=%b v=%b rdy=%b, required 0 0 1", so, so_valid, load_ready);
    end
    $display("[TB] single frame 1011 checked");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bits;
    exp_bits   = 8'b0110_1011;  // bit i is the i-th serial bit
    din        = 4'b1011;
    load_valid = 1'b1;
    step();
    din = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) load_valid = 1'b0;
      tests_run++;
      if (so !== exp_bits[i] || so_valid !== 1'b1 || so_last !== (i == 3 || i == 7)) begin
        tests_failed++;
        $display("FAIL b2b bit%0d: so=%b v=%b last=%b, required so=%b v=1 last=%b",
                 i, so, so_valid, so_last, exp_bits[i], (i == 3 || i == 7));
      end
      step();
    end
    tests_run++;
    if (so_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end: so_valid=%b, required 0", so_valid);
    end
    $display("[TB] back-to-back 1011,0110 checked");
  endtask

  task automatic test_hold();
    logic [7:0] exp_bits;
    exp_bits   = 8'b1111_0001;
    din        = 4'b0001;
    load_valid = 1'b1;
    step();
    din = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) load_valid = 1'b0;
      tests_run++;
      if (so !== exp_bits[i] || so_valid !== 1'b1 || load_ready !== (i == 3 || i == 7)) begin
        tests_failed++;
        $display("FAIL hold bit%0d: so=%b v=%b rdy=%b, required so=%b v=1 rdy=%b",
                 i, so, so_valid, load_ready, exp_bits[i], (i == 3 || i == 7));
      end
      step();
    end
    tests_run++;
    if (so_valid !== 1'b0 || load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_end: v=%b rdy=%b, required 0 1", so_valid, load_ready);
    end
    $display("[TB] held load during 0001 frame checked");
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_bits;
    din        = 4'b1011;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    step();
    step();
    // Third bit on the line, mid-cycle: pull reset with no clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (so !== 1'b0 || so_valid !== 1'b0 || busy !== 1'b0 || so_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: so=%b v=%b busy=%b last=%b, required 0 0 0 0",
               so, so_valid, busy, so_last);
    end
    step();
    rst_n = 1'b1;
    step();
    tests_run++;
    if (load_ready !== 1'b1 || so_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset: rdy=%b v=%b, required 1 0", load_ready, so_valid);
    end
    exp_bits   = 4'b0101;
    din        = 4'b0101;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (so !== exp_bits[i] || so_valid !== 1'b1 || so_last !== (i == 3)) begin
        tests_failed++;
        $display("FAIL post_reset_frame bit%0d: so=%b v=%b last=%b, required so=%b v=1 last=%b",
                 i, so, so_valid, so_last, exp_bits[i], (i == 3));
      end
      step();
    end
    tests_run++;
    if (so_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_end: so_valid=%b, required 0", so_valid);
    end
    $display("[TB] mid-frame reset then 0101 checked");
  endtask
`else
  task automatic test_parity();
    logic [4:0] exp_a;
    logic [4:0] exp_b;
    exp_a      = 5'b11011;  // 1,1,0,1 then parity 1
    exp_b      = 5'b00011;  // 1,1,0,0 then parity 0
    din        = 4'b1011;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (so !== exp_a[i] || so_valid !== 1'b1 || so_last !== (i == 4) ||
          load_ready !== (i == 4)) begin
        tests_failed++;
        $display("FAIL parity_a bit%0d: so=%b v=%b last=%b rdy=%b, required so=%b v=1 last=%b rdy=%b",
                 i, so, so_valid, so_last, load_ready, exp_a[i], (i == 4), (i == 4));
      end
      step();
    end
    tests_run++;
    if (so_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL parity_a_end: so_valid=%b, required 0", so_valid);
    end
    din        = 4'b0011;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (so !== exp_b[i] || so_valid !== 1'b1 || so_last !== (i == 4)) begin
        tests_failed++;
        $display("FAIL parity_b bit%0d: so=%b v=%b last=%b, required so=%b v=1 last=%b",
                 i, so, so_valid, so_last, exp_b[i], (i == 4));
      end
      step();
    end
    $display("[TB] parity frames 1011,0011 checked");
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
`ifndef PISO_TX_PARITY_EN
    test_single();
    test_back_to_back();
    test_hold();
    test_reset_mid();
`else
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
